// File: rtl/bankedmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bankedmem_pkg
// Description : Shared size encodings, controller state type and byte-lane
//               helpers for the banked data memory arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package bankedmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_e;

    // Replace the addressed lane(s) of an existing word with right-aligned store data.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  off,
        input logic [1:0]  size
    );
        logic [31:0] mask;
        logic [31:0] data;
        mask = '0;
        data = '0;
        case (size)
            SZ_BYTE: begin
                mask = 32'h0000_00FF << {off, 3'b000};
                data = {24'h0, wdata[7:0]} << {off, 3'b000};
            end
            SZ_HALF: begin
                mask = 32'h0000_FFFF << {off[1], 4'b0000};
                data = {16'h0, wdata[15:0]} << {off[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
        endcase
        return (old_word & ~mask) | data;
    endfunction

    // Shift the addressed lane(s) down to bit 0 and zero-extend.
    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size
    );
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        byte_sh = word >> {off, 3'b000};
        half_sh = word >> {off[1], 4'b0000};
        case (size)
            SZ_BYTE: return {24'h0, byte_sh[7:0]};
            SZ_HALF: return {16'h0, half_sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bankedmem_rr2.sv
`default_nettype none
// ============================================================================
// Module      : bankedmem_rr2
// Description : Two-way round-robin grant picker with fixed-priority
//               (port B wins) override when RR_EN is 0.
// Revision    : 1.0  initial release
// ============================================================================
module bankedmem_rr2 #(
    parameter int unsigned RR_EN = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    logic prefer_b_q;
    logic prefer_b_d;
    logic gnt_a;
    logic gnt_b;

    always_comb begin
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        prefer_b_d = prefer_b_q;
        if (i_en) begin
            if (i_req_a && i_req_b) begin
                if ((RR_EN != 0) && !prefer_b_q) begin
                    gnt_a = 1'b1;
                end else begin
                    gnt_b = 1'b1;
                end
            end else begin
                gnt_a = i_req_a;
                gnt_b = i_req_b;
            end
            // The side just served loses the next contention.
            if (gnt_a) begin
                prefer_b_d = 1'b1;
            end else if (gnt_b) begin
                prefer_b_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer_b_q <= 1'b0;
        end else begin
            prefer_b_q <= prefer_b_d;
        end
    end

    assign o_gnt_a = gnt_a;
    assign o_gnt_b = gnt_b;

endmodule
`default_nettype wire

// File: rtl/bankedmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bankedmem_arbiter
// Description : Fetch/data two-port arbiter in front of a word-wide banked
//               memory, with read-modify-write for sub-word stores.
// Revision    : 1.0  initial release
// ============================================================================
module bankedmem_arbiter #(
    parameter int unsigned IDX_W = 10,
    parameter int unsigned RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [31:0] a_addr,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [1:0]  b_size,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,
    output logic        mem_writeEn,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    input  logic [31:0] mem_readData
);

    import bankedmem_pkg::*;

    localparam logic [32:0] ADDR_LIMIT = 33'd4 << IDX_W;

    state_e      state_q,       state_d;
    logic [31:0] merge_addr_q,  merge_addr_d;
    logic [31:0] merge_old_q,   merge_old_d;
    logic [31:0] merge_wdata_q, merge_wdata_d;
    logic [1:0]  merge_off_q,   merge_off_d;
    logic [1:0]  merge_size_q,  merge_size_d;
    logic        a_rvalid_q,    a_rvalid_d;
    logic [31:0] a_rdata_q,     a_rdata_d;
    logic        a_err_q,       a_err_d;
    logic        b_rvalid_q,    b_rvalid_d;
    logic [31:0] b_rdata_q,     b_rdata_d;
    logic        b_err_q,       b_err_d;

    logic        can_grant;
    logic        gnt_a;
    logic        gnt_b;
    logic        a_bad;
    logic        b_bad;
    logic        b_misaligned;

    // Grants are suppressed while reset is held so every output reads 0.
    assign can_grant = (state_q == IDLE) && rst_n;

    bankedmem_rr2 #(
        .RR_EN (RR_EN)
    ) u_rr2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (can_grant),
        .i_req_a (a_req),
        .i_req_b (b_req),
        .o_gnt_a (gnt_a),
        .o_gnt_b (gnt_b)
    );

    assign a_bad = (a_addr[1:0] != 2'b00) || ({1'b0, a_addr} >= ADDR_LIMIT);

    assign b_misaligned = (b_size == SZ_BAD)
                       || ((b_size == SZ_HALF) && b_addr[0])
                       || ((b_size == SZ_WORD) && (b_addr[1:0] != 2'b00));
    assign b_bad = b_misaligned || ({1'b0, b_addr} >= ADDR_LIMIT);

    always_comb begin
        state_d       = state_q;
        merge_addr_d  = merge_addr_q;
        merge_old_d   = merge_old_q;
        merge_wdata_d = merge_wdata_q;
        merge_off_d   = merge_off_q;
        merge_size_d  = merge_size_q;
        a_rvalid_d    = 1'b0;
        a_rdata_d     = '0;
        a_err_d       = 1'b0;
        b_rvalid_d    = 1'b0;
        b_rdata_d     = '0;
        b_err_d       = 1'b0;
        mem_writeEn   = 1'b0;
        mem_address   = '0;
        mem_writeData = '0;

        case (state_q)
            IDLE: begin
                if (gnt_a) begin
                    a_rvalid_d = 1'b1;
                    a_err_d    = a_bad;
                    if (!a_bad) begin
                        mem_address = {a_addr[31:2], 2'b00};
                        a_rdata_d   = mem_readData;
                    end
                end
                if (gnt_b) begin
                    if (b_bad) begin
                        b_rvalid_d = 1'b1;
                        b_err_d    = 1'b1;
                    end else begin
                        mem_address = {b_addr[31:2], 2'b00};
                        if (!b_we) begin
                            b_rvalid_d = 1'b1;
                            b_rdata_d  = lane_extract(mem_readData, b_addr[1:0], b_size);
                        end else if (b_size == SZ_WORD) begin
                            b_rvalid_d    = 1'b1;
                            mem_writeEn   = 1'b1;
                            mem_writeData = b_wdata;
                        end else begin
                            // Sub-word store: snapshot the old word, write it back next cycle.
                            merge_addr_d  = {b_addr[31:2], 2'b00};
                            merge_old_d   = mem_readData;
                            merge_wdata_d = b_wdata;
                            merge_off_d   = b_addr[1:0];
                            merge_size_d  = b_size;
                            state_d       = MERGE;
                        end
                    end
                end
            end
            MERGE: begin
                mem_address   = merge_addr_q;
                mem_writeEn   = 1'b1;
                mem_writeData = lane_merge(merge_old_q, merge_wdata_q, merge_off_q, merge_size_q);
                b_rvalid_d    = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            merge_addr_q  <= '0;
            merge_old_q   <= '0;
            merge_wdata_q <= '0;
            merge_off_q   <= '0;
            merge_size_q  <= '0;
            a_rvalid_q    <= 1'b0;
            a_rdata_q     <= '0;
            a_err_q       <= 1'b0;
            b_rvalid_q    <= 1'b0;
            b_rdata_q     <= '0;
            b_err_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            merge_addr_q  <= merge_addr_d;
            merge_old_q   <= merge_old_d;
            merge_wdata_q <= merge_wdata_d;
            merge_off_q   <= merge_off_d;
            merge_size_q  <= merge_size_d;
            a_rvalid_q    <= a_rvalid_d;
            a_rdata_q     <= a_rdata_d;
            a_err_q       <= a_err_d;
            b_rvalid_q    <= b_rvalid_d;
            b_rdata_q     <= b_rdata_d;
            b_err_q       <= b_err_d;
        end
    end

    assign a_gnt    = gnt_a;
    assign b_gnt    = gnt_b;
    assign a_rvalid = a_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign a_err    = a_err_q;
    assign b_rvalid = b_rvalid_q;
    assign b_rdata  = b_rdata_q;
    assign b_err    = b_err_q;

endmodule
`default_nettype wire

// File: doc/bankedmem_arbiter.md
Name: bankedmem_arbiter

Overview:
- Two-requester controller in front of the 4 KB word-wide banked data memory (1024 x 32, four byte banks, combinational read, posedge write, word-only writes).
- Port A is the instruction-fetch port and only reads. Port B is the data port: load/store, sizes byte/half/word.
- Arbitrates A vs B and performs read-modify-write so sub-word stores never corrupt neighbouring bytes.
- Flags misaligned and out-of-range accesses.

Parameters:
- IDX_W, 10, memory word-index width; legal byte range is 0 .. (4<<IDX_W)-1.
- RR_EN, 1, 1 = round-robin on contention; 0 = fixed priority to port B.

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  fetch request; address held stable until a_gnt.
- a_addr  in  32  fetch byte address.
- a_gnt  out  1  request accepted this cycle.
- a_rvalid  out  1  one-cycle response pulse.
- a_rdata  out  32  fetched word.
- a_err  out  1  qualifies a_rvalid: misaligned or out-of-range.
- b_req  in  1  data request; all b_* inputs held stable until b_gnt.
- b_we  in  1  1 = store, 0 = load.
- b_size  in  2  00 byte, 01 half, 10 word; 11 is an error.
- b_addr  in  32  data byte address.
- b_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- b_gnt  out  1  request accepted this cycle.
- b_rvalid  out  1  one-cycle completion pulse, for loads and stores.
- b_rdata  out  32  load data, shifted to bit 0 and zero-extended; 0 for stores.
- b_err  out  1  qualifies b_rvalid.
- mem_writeEn  out  1  to memory write enable.
- mem_address  out  32  to memory; word-aligned ([1:0] = 00).
- mem_writeData  out  32  to memory write data.
- mem_readData  in  32  from memory, combinational from mem_address.

Behaviour:
- Reset (async, rst_n = 0): state = IDLE; all outputs 0; priority pointer favours A.
- States: IDLE, MERGE.
- Error check at acceptance:
  - Misaligned: half with addr[0] = 1; word with addr[1:0] != 0; b_size = 11. Port A is word-only.
  - Out of range: addr >= 4<<IDX_W.
  - Erroring requests are granted, never drive mem_writeEn, respond next cycle with err = 1 and rdata = 0.
- IDLE arbitration:
  - Grant only in IDLE, at most one gnt per cycle.
  - Single requester wins.
  - Both requesting, RR_EN = 1: winner is the side not granted most recently at the last contention or grant; the pointer updates on every grant. RR_EN = 0: B wins.
- Word read or word store, granted in cycle N:
  - Cycle N: mem_address = {addr[31:2], 2'b00}. For a store, mem_writeEn = 1 and mem_writeData = b_wdata. For a load, mem_readData is captured.
  - Cycle N+1: rvalid pulses. IDLE may grant again in N+1, giving 1 access/cycle throughput.
- Sub-word load: same timing as word read; the selected lane is shifted down by addr[1:0] (byte) or addr[1] (half) and zero-extended.
- Sub-word store, granted in cycle N:
  - Cycle N: mem_readData is captured into a merge register together with the word address, lane and size. State goes to MERGE. No write in cycle N.
  - Cycle N+1 (MERGE): mem_address = captured address; mem_writeData = old word with the target lane(s) replaced by b_wdata[7:0] or [15:0]; mem_writeEn = 1. a_gnt = b_gnt = 0.
  - Cycle N+2: b_rvalid = 1; state returns to IDLE, which may grant in N+2.
- Memory outputs when idle:
  - No grant and not in MERGE: mem_writeEn = 0, mem_address = 0.
  - mem_writeEn is never asserted for loads, errors, or port A.
- Requester behaviour:
  - Request dropped before gnt: ignored, no response.
  - Responses always return in grant order; only one access is outstanding per port.
- Reset asserted during MERGE: the write is abandoned (mem_writeEn goes to 0 asynchronously), the memory word is unchanged and no response is issued.
- Writes during IDLE and a read in the following cycle: the read sees the new data, since the memory write lands at the posedge ending cycle N.

Decomposition:
- Shared package holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum {IDLE, MERGE};
  - the function lane_merge(old, wdata, off, size);
  - the function lane_extract(word, off, size).
- One natural sub-module: bankedmem_rr2, a 2-way round-robin picker with the RR_EN fixed-priority override.
- Integration test instantiates bankedmem_arbiter driving the existing banked memory.

Test Plan:
1. Reset then B word store 0xDEADBEEF @0x10 -> b_gnt cycle 0, mem_writeEn = 1 cycle 0, b_rvalid cycle 1; A read @0x10 -> a_rdata = 0xDEADBEEF, a_err = 0.
2. Preload 0x11223344 @0x20; B byte store 0xAA @0x22 -> no write in grant cycle, MERGE writes 0x11AA3344, b_rvalid at N+2; B byte load @0x22 -> b_rdata = 0x000000AA.
3. A and B both request continuously, RR_EN = 1 -> grants alternate A, B, A, B; with RR_EN = 0 -> B every cycle while b_req is held.
4. Half store 0xBEEF @0x31 -> b_err = 1, no mem_writeEn, memory unchanged. A read @0x1000 (IDX_W = 10) -> a_err = 1, a_rdata = 0.
5. A requests during B's MERGE cycle -> a_gnt = 0 in MERGE, a_gnt = 1 the following cycle.
6. Assert rst_n = 0 mid-MERGE of a byte store to 0x40 holding 0x55667788 -> mem_writeEn drops immediately, word stays 0x55667788, no b_rvalid, all outputs 0.
